// File: rtl/pe1_pass_sched.sv
// rtl/pe1_pass_sched.sv - PE1 pass scheduler: sequences NTT/INTT passes, issue addresses, write-back and twiddles
module pe1_pass_sched #(
  parameter int LOG_NBF_K = 6,
  parameter int LOG_NBF_D = 7,
  parameter int LAT_K2    = 4,
  parameter int LAT_K4N   = 4,
  parameter int LAT_K4I   = 14,
  parameter int LAT_D     = 4,
  parameter int TW_AW     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_kd,
  input  logic                 op_inv,
  input  logic                 hold,
  output logic                 sel_0,
  output logic                 sel_1,
  output logic                 KD_mode,
  output logic                 rd_en,
  output logic [LOG_NBF_D-1:0] rd_addr,
  output logic                 wr_en,
  output logic [LOG_NBF_D-1:0] wr_addr,
  output logic [TW_AW-1:0]     tw_addr,
  output logic [2:0]           pass_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_A = (LAT_K2 > LAT_K4N) ? LAT_K2 : LAT_K4N;
  localparam int MAX_B = (LAT_K4I > LAT_D) ? LAT_K4I : LAT_D;
  localparam int DL    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int AW    = $clog2(DL);
  localparam logic [LOG_NBF_D-1:0] LAST_K = LOG_NBF_D'((1 << LOG_NBF_K) - 1);
  localparam logic [LOG_NBF_D-1:0] LAST_D = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic                 kd;
  logic                 inv;
  logic [LOG_NBF_D-1:0] j;
  logic [AW-1:0]        cnt;
  logic [AW-1:0]        tap;
  logic [DL-1:0]        dl_v;
  logic [LOG_NBF_D-1:0] dl_a [DL];
  logic [2:0]           sel;
  logic [2:0]           last_pass;
  logic [LOG_NBF_D-1:0] last_j;
  logic [LOG_NBF_D-1:0] jsh;
  int                   lg;
  int                   sh;

  function automatic logic [2:0] sel_for(input logic k, input logic i, input logic [2:0] p);
    if (k) return i ? 3'b110 : 3'b100;
    else if (!i) return (p == 3'd3) ? 3'b000 : 3'b001;
    else return (p == 3'd0) ? 3'b010 : 3'b011;
  endfunction

  assign sel       = {KD_mode, sel_1, sel_0};
  assign last_pass = kd ? 3'd7 : 3'd3;
  assign last_j    = kd ? LAST_D : LAST_K;
  assign rd_en     = (state == S_ISSUE) && !hold;
  assign rd_addr   = j;
  // The tap follows the pass type; the line is flushed at every pass boundary.
  assign wr_en     = dl_v[tap];
  assign wr_addr   = dl_a[tap];

  always_comb begin
    case (sel)
      3'b000, 3'b010: tap = AW'(LAT_K2 - 1);
      3'b001:         tap = AW'(LAT_K4N - 1);
      3'b011:         tap = AW'(LAT_K4I - 1);
      default:        tap = AW'(LAT_D - 1);
    endcase
  end

  always_comb begin
    lg      = kd ? LOG_NBF_D : LOG_NBF_K;
    sh      = lg - ((int'(pass_idx) < lg) ? int'(pass_idx) : lg);
    jsh     = j >> sh;
    tw_addr = '0;
    if (state == S_ISSUE) tw_addr = TW_AW'({pass_idx, jsh});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      kd                      <= 1'b0;
      inv                     <= 1'b0;
      j                       <= '0;
      cnt                     <= '0;
      pass_idx                <= '0;
      {KD_mode, sel_1, sel_0} <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      dl_v                    <= '0;
      for (int i = 0; i < DL; i++) dl_a[i] <= '0;
    end else begin
      dl_v    <= {dl_v[DL-2:0], rd_en};
      dl_a[0] <= j;
      for (int i = 1; i < DL; i++) dl_a[i] <= dl_a[i-1];
      case (state)
        S_IDLE: begin
          if (start) begin
            kd                      <= op_kd;
            inv                     <= op_inv;
            pass_idx                <= '0;
            j                       <= '0;
            {KD_mode, sel_1, sel_0} <= sel_for(op_kd, op_inv, 3'd0);
            busy                    <= 1'b1;
            state                   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rd_en) begin
            if (j == last_j) begin
              j     <= '0;
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt == tap) begin
            dl_v <= '0;
            if (pass_idx == last_pass) begin
              pass_idx                <= '0;
              {KD_mode, sel_1, sel_0} <= '0;
              busy                    <= 1'b0;
              done                    <= 1'b1;
              state                   <= S_DONE;
            end else begin
              pass_idx                <= pass_idx + 3'd1;
              {KD_mode, sel_1, sel_0} <= sel_for(kd, inv, pass_idx + 3'd1);
              state                   <= S_ISSUE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe1_pass_sched.sv
// tb/tb_pe1_pass_sched.sv - self-checking bench for pe1_pass_sched
module tb_pe1_pass_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op_kd = 1'b0;
  logic        op_inv = 1'b0;
  logic        hold = 1'b0;
  logic        sel_0, sel_1, KD_mode, rd_en, wr_en, busy, done;
  logic [6:0]  rd_addr, wr_addr;
  logic [10:0] tw_addr;
  logic [2:0]  pass_idx;

  pe1_pass_sched dut (
    .clk(clk), .rst(rst), .start(start), .op_kd(op_kd), .op_inv(op_inv), .hold(hold),
    .sel_0(sel_0), .sel_1(sel_1), .KD_mode(KD_mode), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .tw_addr(tw_addr), .pass_idx(pass_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam int MAXN = 2048;
  int errors = 0;
  int checks = 0;
  int cur_n  = 0;
  bit hold_pat [MAXN];
  bit start_pat[MAXN];
  bit e_rd  [MAXN];
  bit e_bub [MAXN];
  bit e_wr  [MAXN];
  bit e_busy[MAXN];
  int e_j   [MAXN];
  int e_wj  [MAXN];
  int e_sel [MAXN];
  int e_pass[MAXN];
  int e_tw  [MAXN];
  int done_n, obs_done, obs_sel_first, obs_sel_last;
  bit e_kd;

  typedef struct {
    bit kd; bit inv; int hstart; int hlen; int smid; int exp_done; int sel0; int sel_last;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cur_n, act, exp);
    end
  endtask

  function automatic int sel_of(bit kd, bit inv, int p);
    if (kd) return inv ? 6 : 4;
    if (!inv) return (p < 3) ? 1 : 0;
    return (p == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(int s);
    case (s)
      0, 2:    return 4;
      1:       return 4;
      3:       return 14;
      default: return 4;
    endcase
  endfunction

  task automatic clear_pats();
    for (int i = 0; i < MAXN; i++) begin
      hold_pat[i] = 0; start_pat[i] = 0;
    end
  endtask

  // Reference timeline: walk the pass list issue by issue, inserting a bubble per held cycle.
  task automatic build(input bit kd, input bit inv);
    int n, nbf, np, lg, s, L, sh;
    for (int i = 0; i < MAXN; i++) begin
      e_rd[i] = 0; e_bub[i] = 0; e_wr[i] = 0; e_busy[i] = 0;
      e_j[i] = 0; e_wj[i] = 0; e_sel[i] = 0; e_pass[i] = 0; e_tw[i] = 0;
    end
    nbf = kd ? 128 : 64; np = kd ? 8 : 4; lg = kd ? 7 : 6; n = 1;
    for (int p = 0; p < np; p++) begin
      s = sel_of(kd, inv, p); L = lat_of(s); sh = lg - ((p < lg) ? p : lg);
      for (int j = 0; j < nbf; j++) begin
        while (hold_pat[n]) begin
          e_busy[n] = 1; e_sel[n] = s; e_pass[n] = p; e_bub[n] = 1; e_j[n] = j; n++;
        end
        e_busy[n] = 1; e_sel[n] = s; e_pass[n] = p; e_rd[n] = 1; e_j[n] = j;
        e_tw[n] = (p << 7) | (j >> sh);
        e_wr[n+L] = 1; e_wj[n+L] = j;
        n++;
      end
      repeat (L) begin
        e_busy[n] = 1; e_sel[n] = s; e_pass[n] = p; n++;
      end
    end
    done_n = n;
  endtask

  task automatic run(input bit kd, input bit inv, input int n_stop);
    op_kd = kd; op_inv = inv; start = 1'b1; hold = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    obs_done = -1; obs_sel_first = -1; obs_sel_last = -1;
    for (int n = 1; n <= done_n + 2 && n <= n_stop; n++) begin
      cur_n = n;
      hold = hold_pat[n]; start = start_pat[n];
      op_kd = 1'($urandom); op_inv = 1'($urandom);
      #1;
      chk("busy", busy, e_busy[n]);
      chk("done", done, (n == done_n) ? 1 : 0);
      chk("rd_en", rd_en, e_rd[n]);
      chk("wr_en", wr_en, e_wr[n]);
      chk("sel", {KD_mode, sel_1, sel_0}, e_sel[n]);
      if (e_rd[n] || e_bub[n]) chk("rd_addr", rd_addr, e_j[n]);
      if (e_rd[n]) chk("tw_addr", tw_addr, e_tw[n]);
      if (e_wr[n]) chk("wr_addr", wr_addr, e_wj[n]);
      if (e_busy[n]) chk("pass_idx", pass_idx, e_pass[n]);
      if (e_kd && e_rd[n] && e_pass[n] == 2 && (e_j[n] % 32) == 0)
        chk("tw_pass2", tw_addr, 'h100 + e_j[n] / 32);
      if (done && obs_done < 0) obs_done = n;
      if (n == 1) obs_sel_first = {KD_mode, sel_1, sel_0};
      if (n == done_n - 1) obs_sel_last = {KD_mode, sel_1, sel_0};
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_sel"}, {KD_mode, sel_1, sel_0}, 0);
    chk({tag, "_pass_idx"}, pass_idx, 0);
    chk({tag, "_tw_addr"}, tw_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  initial begin
    vt[0] = '{kd: 0, inv: 0, hstart: 0,   hlen: 0, smid: 100, exp_done: 273,  sel0: 1, sel_last: 0};
    vt[1] = '{kd: 0, inv: 1, hstart: 0,   hlen: 0, smid: 150, exp_done: 303,  sel0: 2, sel_last: 3};
    vt[2] = '{kd: 1, inv: 1, hstart: 0,   hlen: 0, smid: 400, exp_done: 1057, sel0: 6, sel_last: 6};
    vt[3] = '{kd: 0, inv: 0, hstart: 79,  hlen: 3, smid: 66,  exp_done: 276,  sel0: 1, sel_last: 0};
    vt[4] = '{kd: 1, inv: 0, hstart: 128, hlen: 2, smid: 500, exp_done: 1059, sel0: 4, sel_last: 4};
    vt[5] = '{kd: 0, inv: 1, hstart: 64,  hlen: 1, smid: 200, exp_done: 304,  sel0: 2, sel_last: 3};

    repeat (3) @(posedge clk);
    #1;
    cur_n = 0;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vt[v]) begin
      clear_pats();
      for (int k = 0; k < vt[v].hlen; k++) hold_pat[vt[v].hstart + k] = 1;
      build(vt[v].kd, vt[v].inv);
      start_pat[vt[v].smid] = 1;
      start_pat[done_n] = 1;
      e_kd = vt[v].kd;
      run(vt[v].kd, vt[v].inv, 100000);
      chk("done_cycle", obs_done, vt[v].exp_done);
      chk("sel_first", obs_sel_first, vt[v].sel0);
      chk("sel_last", obs_sel_last, vt[v].sel_last);
    end

    // Abort during the pass-2 drain of a Kyber NTT, then restart cleanly.
    clear_pats();
    build(0, 0);
    e_kd = 0;
    run(0, 0, 202);
    rst = 1'b0;
    #1;
    cur_n = 203;
    chk_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cur_n = 1000 + k;
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rd_en", rd_en, 0);
      @(posedge clk); #1;
    end
    clear_pats();
    build(0, 0);
    run(0, 0, 100000);
    chk("restart_done_cycle", obs_done, 273);

    for (int r = 0; r < 4; r++) begin
      bit kd, inv;
      kd  = 1'($urandom);
      inv = 1'($urandom);
      clear_pats();
      for (int n = 1; n < 1500; n++) hold_pat[n] = ($urandom_range(0, 7) == 0);
      build(kd, inv);
      repeat (3) start_pat[$urandom_range(1, done_n)] = 1;
      e_kd = kd;
      run(kd, inv, 100000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
